ysyx_22050612_mem_responder: RTL and testbench

- Memory-side responder for the core's data/instruction memory port.
- Accepts one read or write request at a time over a valid/ready request channel.
- Holds the request for a programmable latency, then performs the access on an internal 64-bit-wide array.
- Returns a valid/ready response. This replaces the zero-latency DPI memory path with a cycle-accurate synthesizable slave that the LSU/IFU initiators talk to.

---
 rtl/ysyx_22050612_mem_responder_if.sv | 23 ++
 rtl/ysyx_22050612_mem_responder.sv | 129 ++++++++++++
 tb/tb_ysyx_22050612_mem_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050612_mem_responder_if.sv
// Request/response channel between an LSU/IFU initiator and the memory responder.
interface ysyx_22050612_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_22050612_mem_responder.sv
// Single-outstanding memory responder with programmable latency over a 64-bit array.
// Optional YSYX_22050612_MEM_RANDOM_DELAY_EN adds 0..3 LFSR-driven extra latency cycles.
module ysyx_22050612_mem_responder #(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_22050612_mem_responder_if.slave  bus
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_r;
  logic        wen_r;
  logic [63:0] addr_r;
  logic [63:0] wdata_r;
  logic [7:0]  wmask_r;
  logic [4:0]  cnt_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [63:0] resp_rdata_r;
  logic [63:0] mem_r [DEPTH];

  logic          in_range_s;
  logic [AW-1:0] index_s;
  logic          access_s;
  logic          accept_s;
  logic [4:0]    load_cnt_s;

  // Decode of the captured request and handshake qualifiers
  always_comb begin
    in_range_s = (addr_r >= BASE) && (addr_r < LIMIT);
    index_s    = AW'((addr_r - BASE) >> 3);
    access_s   = (state_r == BUSY) && (cnt_r == 5'd0);
    accept_s   = bus.req_valid && req_ready_r && (state_r == IDLE);
  end

`ifdef YSYX_22050612_MEM_RANDOM_DELAY_EN
  logic [7:0] lfsr_r;

  // Fibonacci LFSR, taps 8,6,5,4, free-running from a fixed seed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_r <= 8'hA5;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  assign load_cnt_s = 5'(LATENCY - 1) + {3'd0, lfsr_r[1:0]};
`else
  assign load_cnt_s = 5'(LATENCY - 1);
`endif

  // Array write port; contents survive reset and out-of-range writes never land
  always_ff @(posedge clk) begin
    if (rst_n && access_s && wen_r && in_range_s) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask_r[b]) begin
          mem_r[index_s][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

  // Request capture, latency countdown and response holding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      wen_r        <= 1'b0;
      addr_r       <= 64'd0;
      wdata_r      <= 64'd0;
      wmask_r      <= 8'd0;
      cnt_r        <= 5'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wen_r       <= bus.req_wen;
            addr_r      <= bus.req_addr;
            wdata_r     <= bus.req_wdata;
            wmask_r     <= bus.req_wmask;
            cnt_r       <= load_cnt_s;
            req_ready_r <= 1'b0;
            state_r     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_r != 5'd0) begin
            cnt_r <= cnt_r - 5'd1;
          end else begin
            resp_err_r   <= ~in_range_s;
            resp_rdata_r <= (in_range_s && !wen_r) ? mem_r[index_s] : 64'd0;
            resp_valid_r <= 1'b1;
            state_r      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_ysyx_22050612_mem_responder.sv
// Scoreboard bench for ysyx_22050612_mem_responder: reference array model, latency,
// stall, out-of-range and reset-abort checks.
module tb_ysyx_22050612_mem_responder;
  localparam int          LAT  = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          DEPTH = 1024;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050612_mem_responder_if bus();

  ysyx_22050612_mem_responder #(
    .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  exp_t sb[$];
  logic [63:0] model [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'd8 * 64'(DEPTH));
  endfunction

  function automatic int idx_of(input logic [63:0] a);
    logic [63:0] off;
    off = (a - BASE) >> 3;
    return int'(off[9:0]);
  endfunction

  task automatic idle_bus();
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = 64'd0;
    bus.req_wdata = 64'd0; bus.req_wmask = 8'd0; bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one request, wait for the accept edge, returns when accepted
  task automatic drive_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask);
    logic rdy;
    int   n;
    bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_wmask = wmask;
    n = 0;
    do begin
      rdy = bus.req_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) check("accept_timeout", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wmask, input int hold, output int lat);
    exp_t e, got;
    logic [63:0] w;
    logic [63:0] held;
    e.err = !in_range(addr);
    e.rdata = 64'd0;
    if (!e.err) begin
      if (wen) begin
        w = model.exists(idx_of(addr)) ? model[idx_of(addr)] : 64'd0;
        for (int b = 0; b < 8; b++) if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
        model[idx_of(addr)] = w;
      end else begin
        e.rdata = model[idx_of(addr)];
      end
    end
    sb.push_back(e);
    drive_req(wen, addr, wdata, wmask);
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) check("resp_timeout", {63'd0, bus.resp_valid}, 64'd1);
`ifdef YSYX_22050612_MEM_RANDOM_DELAY_EN
    check("latency_range", {63'd0, (lat >= LAT && lat <= LAT + 3)}, 64'd1);
`else
    check("latency", 64'(lat), 64'(LAT));
`endif
    got = sb.pop_front();
    check("rdata", bus.resp_rdata, got.rdata);
    check("err", {63'd0, bus.resp_err}, {63'd0, got.err});
    held = bus.resp_rdata;
    // Stall the response while a competing request is offered
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = BASE;
      bus.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF; bus.req_wmask = 8'hFF;
      @(posedge clk); #1;
      check("hold_valid", {63'd0, bus.resp_valid}, 64'd1);
      check("hold_rdata", bus.resp_rdata, held);
      check("hold_ready", {63'd0, bus.req_ready}, 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("resp_drop", {63'd0, bus.resp_valid}, 64'd0);
    check("ready_back", {63'd0, bus.req_ready}, 64'd1);
  endtask

  int lat;
  int lats_a [4];
  int lats_b [4];

  initial begin
    idle_bus();
    do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst_rdata", bus.resp_rdata, 64'd0);
    check("rst_err", {63'd0, bus.resp_err}, 64'd0);
    rst_n = 1'b1;

    txn(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0, lat);
    txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, lat);
    check("full_word", model[1], 64'h1122_3344_5566_7788);
    txn(1'b1, 64'h8000_0008, 64'h0000_0000_AABB_CCDD, 8'h0F, 0, lat);
    txn(1'b0, 64'h8000_000C, 64'd0, 8'h00, 0, lat);
    txn(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, lat);
    txn(1'b0, 64'h8000_2000, 64'd0, 8'h00, 0, lat);
    txn(1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, lat);
    txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, lat);
    txn(1'b1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'h00, 0, lat);
    txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 5, lat);
    txn(1'b1, 64'h8000_1FF8, 64'h5A5A_5A5A_A5A5_A5A5, 8'hF0, 0, lat);
    txn(1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 0, lat);

    // Known value, then an aborted overwrite of it
    txn(1'b1, 64'h8000_0010, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 0, lat);
    drive_req(1'b1, 64'h8000_0010, 64'h9999_9999_9999_9999, 8'hFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("abort_ready", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_quiet", {63'd0, bus.resp_valid}, 64'd0);
    end
    txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, lat);

    // Latency sequence must repeat identically after each reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, lat);
      lats_a[i] = lat;
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, lat);
      lats_b[i] = lat;
    end
    for (int i = 0; i < 4; i++) check("lat_repeat", 64'(lats_b[i]), 64'(lats_a[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
